// File: rtl/cvp14_pkg.sv
// cvp14_pkg: shared arbiter state encoding and burst-length default
package cvp14_pkg;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;
  localparam int BURST_LEN_DEF = 16;
endpackage

// File: rtl/arb_beat_counter.sv
// arb_beat_counter: counts owner beats since the last grant change, saturating at BURST_LEN
module arb_beat_counter import cvp14_pkg::*; #(
  parameter int BURST_LEN = BURST_LEN_DEF,
  localparam int CW = $clog2(BURST_LEN + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic          inc_i,
  output logic [CW-1:0] count_o,
  output logic          at_limit_o
);
  logic [CW-1:0] count_q, count_d;
  assign at_limit_o = count_q == CW'(BURST_LEN);
  assign count_o = count_q;
  always_comb count_d = clear_i ? '0 : (inc_i && !at_limit_o) ? count_q + 1'b1 : count_q;
  always_ff @(posedge clk_i) count_q <= rst_i ? '0 : count_d;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-port round-robin memory bus arbiter with locked bursts
module mem_port_arbiter import cvp14_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic              Clk1,
  input  logic              Reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic              rd0,
  input  logic              rd1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] Addr,
  output logic              RD,
  output logic              WR,
  output logic [DATA_W-1:0] DataOut,
  input  logic [DATA_W-1:0] DataIn,
  output logic              err
);
  localparam int CW = $clog2(BURST_LEN + 1);
  arb_state_t state_q, state_d;
  logic last_q, last_d, rvalid0_q, rvalid1_q;
  logic o_rd, o_wr, beat, burst_done, at_limit;
  logic [CW-1:0] count;
  assign gnt0 = state_q == OWN0;
  assign gnt1 = state_q == OWN1;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata = DataIn;
  arb_beat_counter #(.BURST_LEN(BURST_LEN)) u_cnt (
    .clk_i(Clk1),
    .rst_i(Reset),
    .clear_i(state_d != state_q),
    .inc_i(beat),
    .count_o(count),
    .at_limit_o(at_limit)
  );
  // last_q is the port that most recently left ownership; a tie goes to the other one
  always_comb begin
    o_rd = gnt0 ? rd0 : gnt1 & rd1;
    o_wr = gnt0 ? wr0 : gnt1 & wr1;
    RD = o_rd & ~o_wr;
    WR = o_wr & ~o_rd;
    Addr = gnt0 ? addr0 : gnt1 ? addr1 : '0;
    DataOut = gnt0 ? wdata0 : gnt1 ? wdata1 : '0;
    beat = o_rd ^ o_wr;
    burst_done = at_limit | (count == CW'(BURST_LEN - 1));
    err = ~Reset & ((o_rd & o_wr) | ((rd0 | wr0) & ~gnt0) | ((rd1 | wr1) & ~gnt1));
    state_d = state_q;
    case (state_q)
      IDLE: state_d = (req0 & req1) ? (last_q ? OWN0 : OWN1) : req0 ? OWN0 : req1 ? OWN1 : IDLE;
      OWN0: state_d = !req0 ? (req1 ? OWN1 : IDLE) : (req1 & beat & (~lock0 | burst_done)) ? OWN1 : OWN0;
      OWN1: state_d = !req1 ? (req0 ? OWN0 : IDLE) : (req0 & beat & (~lock1 | burst_done)) ? OWN0 : OWN1;
      default: state_d = IDLE;
    endcase
    last_d = (gnt0 && state_d != OWN0) ? 1'b0 : (gnt1 && state_d != OWN1) ? 1'b1 : last_q;
  end
  always_ff @(posedge Clk1) begin
    if (Reset) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      rvalid0_q <= gnt0 & RD;
      rvalid1_q <= gnt1 & RD;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized run against a behavioural model
module tb_mem_port_arbiter;
  logic Clk1 = 0, Reset = 0;
  logic req0, req1, lock0, lock1, rd0, rd1, wr0, wr1;
  logic [15:0] addr0, addr1, wdata0, wdata1, DataIn;
  logic gnt0, gnt1, rvalid0, rvalid1, RD, WR, err;
  logic [15:0] rdata, Addr, DataOut;
  int checks = 0, failures = 0;

  mem_port_arbiter dut (
    .Clk1(Clk1), .Reset(Reset), .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .rd0(rd0), .rd1(rd1), .wr0(wr0), .wr1(wr1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0),
    .rvalid1(rvalid1), .rdata(rdata), .Addr(Addr), .RD(RD), .WR(WR), .DataOut(DataOut),
    .DataIn(DataIn), .err(err)
  );

  always #5 Clk1 = ~Clk1;

  task automatic tick();
    @(posedge Clk1);
    #1;
  endtask

  task automatic idle_inputs();
    {req0, req1, lock0, lock1, rd0, rd1, wr0, wr1} = '0;
    {addr0, addr1, wdata0, wdata1, DataIn} = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    Reset = 1;
    tick();
    tick();
    Reset = 0;
    #1;
  endtask

  task automatic test_reset();
    req0 = 1; rd0 = 1; lock0 = 1;
    Reset = 1;
    tick();
    idle_inputs();
    tick();
    Reset = 0;
    #1;
    checks++;
    if ({gnt0, gnt1, RD, WR, err, rvalid0, rvalid1} !== 7'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0000000", {gnt0, gnt1, RD, WR, err, rvalid0, rvalid1});
    end
    checks++;
    if ({Addr, DataOut} !== 32'h0) begin
      failures++;
      $display("FAIL reset_bus got=%h exp=00000000", {Addr, DataOut});
    end
  endtask

  task automatic test_single_read();
    do_reset();
    req0 = 1;
    #1;
    checks++;
    if (gnt0 !== 1'b0) begin failures++; $display("FAIL grant_latency_early got=%b exp=0", gnt0); end
    tick();
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin failures++; $display("FAIL grant_single got=%b exp=10", {gnt0, gnt1}); end
    rd0 = 1; addr0 = 16'h0040;
    #1;
    checks++;
    if ({Addr, RD, WR} !== {16'h0040, 2'b10}) begin
      failures++;
      $display("FAIL read_bus got=%h/%b%b exp=0040/10", Addr, RD, WR);
    end
    tick();
    rd0 = 0; DataIn = 16'h1234;
    #1;
    checks++;
    if ({rvalid0, rvalid1, rdata} !== {2'b10, 16'h1234}) begin
      failures++;
      $display("FAIL read_rvalid got=%b%b/%h exp=10/1234", rvalid0, rvalid1, rdata);
    end
    tick();
    checks++;
    if (rvalid0 !== 1'b0) begin failures++; $display("FAIL rvalid_pulse got=%b exp=0", rvalid0); end
  endtask

  task automatic test_tie_rr();
    do_reset();
    req0 = 1; req1 = 1;
    tick();
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin failures++; $display("FAIL tie_first got=%b exp=10", {gnt0, gnt1}); end
    req0 = 0;
    tick();
    checks++;
    if ({gnt0, gnt1} !== 2'b01) begin failures++; $display("FAIL release_handover got=%b exp=01", {gnt0, gnt1}); end
    req1 = 0;
    tick();
    checks++;
    if ({gnt0, gnt1} !== 2'b00) begin failures++; $display("FAIL release_idle got=%b exp=00", {gnt0, gnt1}); end
    req0 = 1; req1 = 1;
    tick();
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin failures++; $display("FAIL tie_rr got=%b exp=10", {gnt0, gnt1}); end
  endtask

  task automatic test_locked_burst();
    int held = 0;
    do_reset();
    req0 = 1; lock0 = 1;
    tick();
    req1 = 1;
    for (int i = 0; i < 16; i++) begin
      rd0 = 1; addr0 = 16'(i);
      #1;
      if (gnt0 && RD) held++;
      tick();
    end
    rd0 = 0;
    #1;
    checks++;
    if (held !== 16) begin failures++; $display("FAIL burst_held got=%0d exp=16", held); end
    checks++;
    if ({gnt0, gnt1} !== 2'b01) begin failures++; $display("FAIL burst_handover got=%b exp=01", {gnt0, gnt1}); end
  endtask

  task automatic test_unlocked_write();
    do_reset();
    req1 = 1;
    tick();
    req0 = 1; lock1 = 0; wr1 = 1; addr1 = 16'h0100; wdata1 = 16'hBEEF;
    #1;
    checks++;
    if ({Addr, DataOut, RD, WR} !== {16'h0100, 16'hBEEF, 2'b01}) begin
      failures++;
      $display("FAIL write_bus got=%h/%h/%b%b exp=0100/beef/01", Addr, DataOut, RD, WR);
    end
    tick();
    wr1 = 0;
    #1;
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin failures++; $display("FAIL unlocked_handover got=%b exp=10", {gnt0, gnt1}); end
  endtask

  task automatic test_err();
    do_reset();
    req0 = 1;
    tick();
    rd0 = 1; wr0 = 1;
    #1;
    checks++;
    if ({RD, WR, err} !== 3'b001) begin failures++; $display("FAIL owner_rdwr got=%b exp=001", {RD, WR, err}); end
    tick();
    rd0 = 0; wr0 = 0;
    #1;
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL err_pulse got=%b exp=0", err); end
    wr1 = 1;
    #1;
    checks++;
    if ({WR, err} !== 2'b01) begin failures++; $display("FAIL nonowner_wr got=%b exp=01", {WR, err}); end
    wr1 = 0;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req0 = 1; lock0 = 1;
    tick();
    req1 = 1;
    for (int i = 0; i < 4; i++) begin
      rd0 = 1;
      tick();
    end
    Reset = 1;
    tick();
    Reset = 0;
    idle_inputs();
    #1;
    checks++;
    if ({gnt0, gnt1, RD, WR, err, rvalid0, rvalid1} !== 7'b0) begin
      failures++;
      $display("FAIL midburst_reset got=%b exp=0000000", {gnt0, gnt1, RD, WR, err, rvalid0, rvalid1});
    end
    checks++;
    if ({Addr, DataOut} !== 32'h0) begin
      failures++;
      $display("FAIL midburst_bus got=%h exp=00000000", {Addr, DataOut});
    end
  endtask

  task automatic test_random();
    int own = -1, cnt = 0, last = 1, nxt;
    bit rv0 = 0, rv1 = 0, o_rd, o_wr, beat, my_req, oth_req, my_lock;
    logic [6:0] exp_flags;
    logic [15:0] exp_addr, exp_dout;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      req0 = $urandom_range(0, 3) != 0; req1 = $urandom_range(0, 3) != 0;
      lock0 = $urandom_range(0, 1) != 0; lock1 = $urandom_range(0, 1) != 0;
      rd0 = $urandom_range(0, 2) == 0; wr0 = $urandom_range(0, 2) == 0;
      rd1 = $urandom_range(0, 2) == 0; wr1 = $urandom_range(0, 2) == 0;
      addr0 = 16'($urandom); addr1 = 16'($urandom);
      wdata0 = 16'($urandom); wdata1 = 16'($urandom); DataIn = 16'($urandom);
      #1;
      o_rd = own == 0 ? rd0 : own == 1 ? rd1 : 0;
      o_wr = own == 0 ? wr0 : own == 1 ? wr1 : 0;
      exp_addr = own == 0 ? addr0 : own == 1 ? addr1 : 16'h0;
      exp_dout = own == 0 ? wdata0 : own == 1 ? wdata1 : 16'h0;
      exp_flags = {own == 0, own == 1, o_rd && !o_wr, o_wr && !o_rd,
                   (o_rd && o_wr) || ((rd0 || wr0) && own != 0) || ((rd1 || wr1) && own != 1), rv0, rv1};
      checks++;
      if ({gnt0, gnt1, RD, WR, err, rvalid0, rvalid1} !== exp_flags) begin
        failures++;
        $display("FAIL rand_flags cyc=%0d got=%b exp=%b", c, {gnt0, gnt1, RD, WR, err, rvalid0, rvalid1}, exp_flags);
      end
      checks++;
      if ({Addr, DataOut} !== {exp_addr, exp_dout}) begin
        failures++;
        $display("FAIL rand_bus cyc=%0d got=%h/%h exp=%h/%h", c, Addr, DataOut, exp_addr, exp_dout);
      end
      checks++;
      if (rdata !== DataIn) begin failures++; $display("FAIL rand_rdata cyc=%0d got=%h exp=%h", c, rdata, DataIn); end
      beat = own >= 0 && (o_rd != o_wr);
      if (own < 0) nxt = (req0 && req1) ? (last == 0 ? 1 : 0) : req0 ? 0 : req1 ? 1 : -1;
      else begin
        my_req = own == 0 ? req0 : req1;
        oth_req = own == 0 ? req1 : req0;
        my_lock = own == 0 ? lock0 : lock1;
        if (!my_req) nxt = oth_req ? 1 - own : -1;
        else if (oth_req && beat && (!my_lock || cnt + 1 >= 16)) nxt = 1 - own;
        else nxt = own;
      end
      rv0 = own == 0 && o_rd && !o_wr;
      rv1 = own == 1 && o_rd && !o_wr;
      if (nxt != own) begin
        if (own >= 0) last = own;
        cnt = 0;
      end else if (beat && cnt < 16) cnt++;
      own = nxt;
      tick();
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_tie_rr();
    test_locked_burst();
    test_unlocked_write();
    test_err();
    test_reset_mid_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
